sci_slave: RTL and testbench

Serial configuration interface (SCI) peripheral endpoint: deserialises SCI frames driven by the SCI master onto its chip-select, request and tri-state response/acknowledge lines, and converts them into a parallel single-beat register-bank access. Sits directly downstream of the SCI master, one instance per peripheral index, in front of each block's configuration register file. Writes produce a one-cycle write strobe. Reads fetch one word and stream it back LSB first.

---
 rtl/sci_slave.sv | 183 ++++++++++++++++++
 tb/tb_sci_slave.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/sci_slave.sv
// SCI peripheral endpoint: serial frame to single-beat register access.
// Optional SCI_SLAVE_ABORT_CNT_EN enables the saturating aborted-frame counter.
module sci_slave #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sci_csn,
  input  logic                  sci_req,
  inout  wire                   sci_resp,
  inout  wire                   sci_ack,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic [DATA_WIDTH-1:0] reg_wdata,
  output logic                  reg_wr_en,
  output logic                  reg_rd_en,
  input  logic [DATA_WIDTH-1:0] reg_rdata,
  output logic [7:0]            abort_cnt
);

  localparam int MAXW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CW   = (MAXW > 1) ? $clog2(MAXW) : 1;

  typedef enum logic [2:0] {
    IDLE, ADDR, WDATA, WR_ACK, RD_FETCH, RD_SHIFT, RD_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  cmd_q, cmd_d;
  logic [ADDR_WIDTH-1:0] ash_q, ash_d;
  logic [DATA_WIDTH-1:0] wsh_q, wsh_d;
  logic [DATA_WIDTH-1:0] rsh_q, rsh_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  wr_en_q, wr_en_d;
  logic                  rd_en_q, rd_en_d;
  logic                  ack_q, ack_d;
  logic                  resp_q, resp_d;
  logic                  abort;

  assign sci_ack  = sci_csn ? 1'bz : ack_q;
  assign sci_resp = sci_csn ? 1'bz : resp_q;

  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign reg_wr_en = wr_en_q;
  assign reg_rd_en = rd_en_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    cmd_d   = cmd_q;
    ash_d   = ash_q;
    wsh_d   = wsh_q;
    rsh_d   = rsh_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_en_d = 1'b0;
    rd_en_d = 1'b0;
    ack_d   = ack_q;
    resp_d  = resp_q;
    abort   = 1'b0;
    if (sci_csn && state_q != IDLE) begin
      // deselect anywhere mid-frame drops the frame without a strobe
      abort   = (state_q == ADDR) || (state_q == WDATA) ||
                (state_q == RD_FETCH) || (state_q == RD_SHIFT);
      state_d = IDLE;
      ack_d   = 1'b0;
      resp_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ack_d  = 1'b0;
          resp_d = 1'b0;
          if (!sci_csn) begin
            cmd_d   = sci_req;
            cnt_d   = '0;
            state_d = ADDR;
          end
        end
        ADDR: begin
          ash_d = {sci_req, ash_q[ADDR_WIDTH-1:1]};
          if (cnt_q == CW'(ADDR_WIDTH - 1)) begin
            addr_d  = ash_d;
            cnt_d   = '0;
            state_d = cmd_q ? WDATA : RD_FETCH;
            rd_en_d = !cmd_q;
          end
        end
        WDATA: begin
          wsh_d = {sci_req, wsh_q[DATA_WIDTH-1:1]};
          if (cnt_q == CW'(DATA_WIDTH - 1)) begin
            wdata_d = wsh_d;
            wr_en_d = 1'b1;
            ack_d   = 1'b1;
            cnt_d   = '0;
            state_d = WR_ACK;
          end
        end
        WR_ACK: begin
          ack_d = 1'b1;
          cnt_d = '0;
        end
        RD_FETCH: begin
          rsh_d   = {1'b0, reg_rdata[DATA_WIDTH-1:1]};
          resp_d  = reg_rdata[0];
          ack_d   = 1'b1;
          cnt_d   = '0;
          state_d = RD_SHIFT;
        end
        RD_SHIFT: begin
          if (cnt_q == CW'(DATA_WIDTH - 1)) begin
            ack_d   = 1'b0;
            resp_d  = 1'b0;
            cnt_d   = '0;
            state_d = RD_DONE;
          end else begin
            resp_d = rsh_q[0];
            rsh_d  = {1'b0, rsh_q[DATA_WIDTH-1:1]};
          end
        end
        RD_DONE: begin
          ack_d  = 1'b0;
          resp_d = 1'b0;
          cnt_d  = '0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cmd_q   <= 1'b0;
      ash_q   <= '0;
      wsh_q   <= '0;
      rsh_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_en_q <= 1'b0;
      rd_en_q <= 1'b0;
      ack_q   <= 1'b0;
      resp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      ash_q   <= ash_d;
      wsh_q   <= wsh_d;
      rsh_q   <= rsh_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_en_q <= wr_en_d;
      rd_en_q <= rd_en_d;
      ack_q   <= ack_d;
      resp_q  <= resp_d;
    end
  end

`ifdef SCI_SLAVE_ABORT_CNT_EN
  logic [7:0] abort_cnt_q, abort_cnt_d;

  always_comb begin
    abort_cnt_d = abort_cnt_q;
    if (abort && abort_cnt_q != 8'hFF) abort_cnt_d = abort_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) abort_cnt_q <= '0;
    else     abort_cnt_q <= abort_cnt_d;
  end

  assign abort_cnt = abort_cnt_q;
`else
  logic unused_abort;
  assign unused_abort = abort;
  assign abort_cnt    = '0;
`endif

endmodule

// File: tb/tb_sci_slave.sv
// Bench for sci_slave: SCI master model, register bank model and
// scoreboards for write strobes, read strobes and serial read data.
module tb_sci_slave;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sci_csn = 1'b1;
  logic       sci_req = 1'b0;
  wire        sci_resp;
  wire        sci_ack;
  logic [3:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_wr_en;
  logic       reg_rd_en;
  logic [7:0] reg_rdata;
  logic [7:0] abort_cnt;

  pullup (sci_ack);
  pullup (sci_resp);

  always #5 clk = ~clk;

  sci_slave #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .sci_csn(sci_csn), .sci_req(sci_req),
    .sci_resp(sci_resp), .sci_ack(sci_ack),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_wr_en(reg_wr_en), .reg_rd_en(reg_rd_en),
    .reg_rdata(reg_rdata), .abort_cnt(abort_cnt)
  );

`ifdef SCI_SLAVE_ABORT_CNT_EN
  localparam logic [7:0] ABORT_EXP = 8'd1;
`else
  localparam logic [7:0] ABORT_EXP = 8'd0;
`endif

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;

  logic [7:0]  bank [16];
  logic [11:0] wq[$];
  logic [3:0]  raq[$];
  logic [7:0]  rq[$];

  assign reg_rdata = bank[reg_addr];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (reg_wr_en) begin
      wr_cnt++;
      if (wq.size() == 0) chk("wr_unexp", wq.size(), 1);
      else chk("wr_beat", {reg_addr, reg_wdata}, wq.pop_front());
      bank[reg_addr] = reg_wdata;
    end
    if (reg_rd_en) begin
      rd_cnt++;
      if (raq.size() == 0) chk("rd_unexp", raq.size(), 1);
      else chk("rd_addr", reg_addr, raq.pop_front());
    end
  end

  task automatic send_bits(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sci_req = v[i];
    end
  endtask

  task automatic wait_ack(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (sci_ack === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wr_frame(input logic [3:0] a, input logic [7:0] d);
    logic ok;
    wq.push_back({a, d});
    @(negedge clk);
    sci_csn = 1'b0;
    sci_req = 1'b1;
    send_bits({4'h0, a}, 4);
    send_bits(d, 8);
    wait_ack(ok);
    chk("wr_ack", ok, 1);
    sci_csn = 1'b1;
    #1 chk("wr_ack_z", sci_ack, 1);
  endtask

  task automatic rd_frame(input logic [3:0] a, input logic [7:0] exp);
    logic       ok;
    logic [7:0] data;
    int         beats;
    raq.push_back(a);
    rq.push_back(exp);
    @(negedge clk);
    sci_csn = 1'b0;
    sci_req = 1'b0;
    send_bits({4'h0, a}, 4);
    wait_ack(ok);
    chk("rd_ack", ok, 1);
    data[0] = sci_resp;
    beats = 1;
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      if (sci_ack === 1'b1) beats++;
      data[i] = sci_resp;
    end
    @(negedge clk);
    chk("rd_ack_end", sci_ack, 0);
    chk("rd_beats", beats, 8);
    chk("rd_data", data, rq.pop_front());
    sci_csn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic ok;
    int   w0, r0;
    for (int i = 0; i < 16; i++) bank[i] = 8'h00;
    bank[12] = 8'h5A;
    bank[7]  = 8'h99;
    bank[1]  = 8'h3C;
    repeat (3) @(negedge clk);
    chk("rst_addr", reg_addr, 0);
    chk("rst_wdata", reg_wdata, 0);
    chk("rst_wr_en", reg_wr_en, 0);
    chk("rst_rd_en", reg_rd_en, 0);
    chk("rst_abort", abort_cnt, 0);
    chk("rst_ack_z", sci_ack, 1);
    rst = 1'b0;

    wr_frame(4'h5, 8'hA3);
    chk("wr1_addr", reg_addr, 4'h5);
    chk("wr1_data", reg_wdata, 8'hA3);

    rd_frame(4'hC, 8'h5A);
    chk("rd1_addr", reg_addr, 4'hC);

    w0 = wr_cnt;
    r0 = rd_cnt;
    sci_req = 1'bx;
    repeat (20) @(negedge clk);
    chk("idle_wr", wr_cnt, w0);
    chk("idle_rd", rd_cnt, r0);
    chk("idle_ack_z", sci_ack, 1);
    chk("idle_resp_z", sci_resp, 1);

    @(negedge clk);
    sci_csn = 1'b0;
    sci_req = 1'b1;
    send_bits(8'h09, 2);
    @(negedge clk);
    sci_csn = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_wr", wr_cnt, w0);
    chk("abort_cnt", abort_cnt, ABORT_EXP);
    wr_frame(4'h3, 8'h11);
    chk("wr2_data", reg_wdata, 8'h11);

    raq.push_back(4'h7);
    @(negedge clk);
    sci_csn = 1'b0;
    sci_req = 1'b0;
    send_bits(8'h07, 4);
    wait_ack(ok);
    chk("rst_rd_ack", ok, 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mrst_ack", sci_ack, 0);
    chk("mrst_resp", sci_resp, 0);
    chk("mrst_wr_en", reg_wr_en, 0);
    chk("mrst_rd_en", reg_rd_en, 0);
    chk("mrst_abort", abort_cnt, 0);
    @(negedge clk);
    sci_csn = 1'b1;
    #1 chk("mrst_ack_z", sci_ack, 1);
    @(negedge clk);
    rst = 1'b0;
    rd_frame(4'h1, 8'h3C);

    w0 = wr_cnt;
    r0 = rd_cnt;
    wr_frame(4'h2, 8'hFF);
    rd_frame(4'h2, 8'hFF);
    repeat (3) @(negedge clk);
    chk("b2b_wr", wr_cnt - w0, 1);
    chk("b2b_rd", rd_cnt - r0, 1);
    chk("tot_wr", wr_cnt, 3);
    chk("tot_rd", rd_cnt, 4);
    chk("wq_empty", wq.size(), 0);
    chk("raq_empty", raq.size(), 0);
    chk("rq_empty", rq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
